// File: rtl/count_neighbors.sv
// Scans the mine board after placement and writes each cell's adjacent-mine count (0..8).
// Optional MINE_MARK_EN: cells that hold a mine are written as 9 instead of their count.
module count_neighbors #(
    parameter int unsigned BoardWidth  = 8,
    parameter int unsigned BoardHeight = 8
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_start,
    input  logic                                        i_ack,
    output logic [((BoardWidth > 1) ? $clog2(BoardWidth) : 1)-1:0]   o_read_x,
    output logic [((BoardHeight > 1) ? $clog2(BoardHeight) : 1)-1:0] o_read_y,
    input  logic                                        i_mine_board_read_value,
    output logic [((BoardWidth > 1) ? $clog2(BoardWidth) : 1)-1:0]   o_write_x,
    output logic [((BoardHeight > 1) ? $clog2(BoardHeight) : 1)-1:0] o_write_y,
    output logic [3:0]                                  o_count_value,
    output logic                                        o_count_write_en,
    output logic [$clog2(BoardWidth * BoardHeight):0]   o_mine_total,
    output logic                                        o_init,
    output logic                                        o_scan,
    output logic                                        o_write,
    output logic                                        o_done
);

    localparam int unsigned XW  = (BoardWidth > 1) ? $clog2(BoardWidth) : 1;
    localparam int unsigned YW  = (BoardHeight > 1) ? $clog2(BoardHeight) : 1;
    localparam int unsigned MTW = $clog2(BoardWidth * BoardHeight) + 1;

    localparam logic signed [XW+1:0] XMax = (XW + 2)'(BoardWidth - 1);
    localparam logic signed [YW+1:0] YMax = (YW + 2)'(BoardHeight - 1);
    localparam logic [XW-1:0] XLast = XW'(BoardWidth - 1);
    localparam logic [YW-1:0] YLast = YW'(BoardHeight - 1);

    typedef enum logic [1:0] {StInit, StScan, StWrite, StDone} state_e;

    state_e           r_state;
    logic [XW-1:0]    r_cx;
    logic [YW-1:0]    r_cy;
    logic [3:0]       r_k;
    logic [3:0]       r_acc;
    logic             r_is_mine;
    logic [MTW-1:0]   r_mine_total;
    logic [XW-1:0]    r_write_x;
    logic [YW-1:0]    r_write_y;
    logic [3:0]       r_count_value;
    logic             r_count_write_en;

    logic signed [1:0]    w_dx;
    logic signed [1:0]    w_dy;
    logic signed [XW+1:0] w_nx;
    logic signed [YW+1:0] w_ny;
    logic                 w_in;
    logic                 w_centre;
    logic [3:0]           w_acc_next;
    logic [3:0]           w_cell_value;
    logic                 w_last_x;
    logic                 w_last_y;

    // Neighbour index k walks the 3x3 window row by row; k=4 is the centre.
    always_comb begin
        w_dx = 2'sb00;
        w_dy = 2'sb00;
        case (r_k)
            4'd0:    begin w_dx = 2'sb11; w_dy = 2'sb11; end
            4'd1:    begin w_dx = 2'sb00; w_dy = 2'sb11; end
            4'd2:    begin w_dx = 2'sb01; w_dy = 2'sb11; end
            4'd3:    begin w_dx = 2'sb11; w_dy = 2'sb00; end
            4'd4:    begin w_dx = 2'sb00; w_dy = 2'sb00; end
            4'd5:    begin w_dx = 2'sb01; w_dy = 2'sb00; end
            4'd6:    begin w_dx = 2'sb11; w_dy = 2'sb01; end
            4'd7:    begin w_dx = 2'sb00; w_dy = 2'sb01; end
            4'd8:    begin w_dx = 2'sb01; w_dy = 2'sb01; end
            default: begin w_dx = 2'sb00; w_dy = 2'sb00; end
        endcase
    end

    // Widened signed sums so that -1 and W are both visible as out of range.
    assign w_nx = $signed({2'b00, r_cx}) + $signed({{XW{w_dx[1]}}, w_dx});
    assign w_ny = $signed({2'b00, r_cy}) + $signed({{YW{w_dy[1]}}, w_dy});
    assign w_in = !w_nx[XW+1] && (w_nx <= XMax) && !w_ny[YW+1] && (w_ny <= YMax);

    assign o_read_x = w_in ? w_nx[XW-1:0] : r_cx;
    assign o_read_y = w_in ? w_ny[YW-1:0] : r_cy;

    assign w_centre   = (r_k == 4'd4);
    assign w_acc_next = r_acc + {3'b000, (w_in && !w_centre && i_mine_board_read_value)};
    assign w_last_x   = (r_cx == XLast);
    assign w_last_y   = (r_cy == YLast);

`ifdef MINE_MARK_EN
    assign w_cell_value = r_is_mine ? 4'd9 : w_acc_next;
`else
    assign w_cell_value = w_acc_next;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= StInit;
            r_cx             <= '0;
            r_cy             <= '0;
            r_k              <= '0;
            r_acc            <= '0;
            r_is_mine        <= 1'b0;
            r_mine_total     <= '0;
            r_write_x        <= '0;
            r_write_y        <= '0;
            r_count_value    <= '0;
            r_count_write_en <= 1'b0;
        end else begin
            r_count_write_en <= 1'b0;
            case (r_state)
                StInit: begin
                    r_cx         <= '0;
                    r_cy         <= '0;
                    r_k          <= '0;
                    r_acc        <= '0;
                    r_is_mine    <= 1'b0;
                    r_mine_total <= '0;
                    if (i_start) begin
                        r_state <= StScan;
                    end
                end
                StScan: begin
                    r_acc <= w_acc_next;
                    if (w_centre) begin
                        r_mine_total <= r_mine_total + MTW'(i_mine_board_read_value);
                        r_is_mine    <= i_mine_board_read_value;
                    end
                    if (r_k == 4'd8) begin
                        r_state          <= StWrite;
                        r_count_write_en <= 1'b1;
                        r_write_x        <= r_cx;
                        r_write_y        <= r_cy;
                        r_count_value    <= w_cell_value;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                StWrite: begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (w_last_x) begin
                        r_cx <= '0;
                        r_cy <= w_last_y ? '0 : r_cy + YW'(1);
                    end else begin
                        r_cx <= r_cx + XW'(1);
                    end
                    r_state <= (w_last_x && w_last_y) ? StDone : StScan;
                end
                StDone: begin
                    if (i_ack) begin
                        r_state <= StInit;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign o_write_x        = r_write_x;
    assign o_write_y        = r_write_y;
    assign o_count_value    = r_count_value;
    assign o_count_write_en = r_count_write_en;
    assign o_mine_total     = r_mine_total;
    assign o_init           = (r_state == StInit);
    assign o_scan           = (r_state == StScan);
    assign o_write          = (r_state == StWrite);
    assign o_done           = (r_state == StDone);

endmodule
